// File: rtl/mc_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package mc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_REJECT = 2'b11
    } state_e;

    localparam logic [31:0] MISALIGN_MASK = 32'h0000_0003;
    localparam int          WAIT_MAX      = 15;
    localparam int          CNT_W         = 4;

    // A byte address is refused when it is not word aligned or lies beyond the array.
    function automatic logic is_rejected(input logic [31:0] addr, input int addr_w);
        return ((addr & MISALIGN_MASK) != 32'd0) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mc_mem_responder_if.sv
// Request/response bus between the CPU controller and the memory responder.
interface mc_mem_if #(parameter int DATA_W = 32) ();

    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (output req, we, addr, wdata, input rdata, ready, busy, err);
    modport slave  (input req, we, addr, wdata, output rdata, ready, busy, err);

endinterface

// File: rtl/mc_mem_responder_array.sv
// Single-port synchronous word RAM; the read port registers the addressed word every cycle.
module mc_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset; contents survive rst and map onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[waddr];
    end

endmodule

// File: rtl/mc_mem_responder.sv
// Memory responder: latches a request, decodes it one cycle later, waits, then pulses ready.
module mc_mem_responder
    import mc_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    mc_mem_if.slave    bus
);

    localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              mem_we;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!busy_q) begin
                    if (bus.req) begin
                        we_d    = bus.we;
                        addr_d  = bus.addr;
                        wdata_d = bus.wdata;
                        busy_d  = 1'b1;
                    end
                end else if (is_rejected(addr_q, ADDR_W)) begin
                    // Second IDLE cycle decodes the latched request.
                    state_d = ST_REJECT;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end else if (WAIT_EFF == 0) begin
                    state_d = ST_ACCESS;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_EFF);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                    ready_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                mem_we  = we_q;
                if (!we_q) begin
                    rdata_d = ram_rdata;
                end
            end
            ST_REJECT: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    mc_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_q[ADDR_W+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // During a read's ACCESS cycle the RAM register already holds the word; it is kept afterwards.
    assign bus.rdata = (state_q == ST_ACCESS && !we_q) ? ram_rdata : rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule

// File: doc/mc_mem_responder.md
Name: mc_mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU controller. It serves the unified instruction/data accesses the controller initiates.
- Each access is accepted with a one-cycle request, held through a programmable number of wait states, then completed with a one-cycle ready pulse. Read data is held afterwards.
- Sits between the controller/datapath address mux (PC or ALU output) and a single-port word memory.
- Flags misaligned or out-of-range accesses instead of performing them.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words.
- DATA_W, 32, data word width.
- WAIT_CYCLES, 2, wait states between acceptance and completion; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  access request, single-cycle pulse; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- rdata  output  DATA_W  read data; valid while ready=1, held until the next read completes.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from acceptance until the cycle after ready.
- err  output  1  high with ready when the access was rejected.

Behaviour:
- Reset (asynchronous, applies immediately):
  - state=IDLE, rdata=0, ready=0, busy=0, err=0, wait counter=0, latched request registers=0.
  - Memory array contents are not cleared.
- States: IDLE, WAIT, ACCESS, REJECT.
- IDLE:
  - ready=0, err=0, busy=0.
  - On req=1 at edge N: latch we/addr/wdata and set busy=1.
  - Reject if addr[1:0]!=0 or addr[31:ADDR_W+2]!=0: go to REJECT.
  - Otherwise load counter=WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else to ACCESS.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1 (the edge that would make it 0), go to ACCESS.
  - req is ignored; inputs may change freely.
- ACCESS (one cycle):
  - Write: mem[addr[ADDR_W+1:2]] <= latched wdata at the exit edge; rdata unchanged.
  - Read: rdata <= mem[latched word address] at the entry edge, so rdata is valid while ready=1.
  - ready=1, err=0. Next state is IDLE.
- REJECT (one cycle):
  - ready=1, err=1. No memory write; rdata unchanged.
  - Next state is IDLE.
- ready and err are registered outputs. busy drops to 0 on entry to IDLE.
- Latency: req at edge N gives ready high during the cycle after edge N+1+WAIT_CYCLES. Examples:
  - WAIT_CYCLES=2: ready high in the cycle after edge N+3.
  - WAIT_CYCLES=0: ready high in the cycle after edge N+1.
  - Rejects always take 1 cycle, independent of WAIT_CYCLES.
- Back-to-back: a req asserted in the ACCESS or REJECT cycle is ignored. The earliest new request is in the cycle after ready falls (IDLE).
- Read-after-write to the same address returns the new data.
- Reset during WAIT or ACCESS:
  - The access is aborted and ready is never issued.
  - A write whose ACCESS exit edge has not occurred is discarded.
- rdata changes only when a read completes or on reset.

Decomposition:
- Package mc_mem_pkg:
  - state encoding constants: IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10, REJECT=2'b11;
  - the misalignment mask constant;
  - the WAIT_CYCLES legal maximum (15).
- Sub-module mc_mem_array: single-port synchronous RAM with ADDR_W and DATA_W parameters and ports clk, we, waddr, wdata, rdata. It has no reset.
- The responder FSM, counter and latch registers live in the top module.

Test Plan:
- Write then read, WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF; then read addr=0x10 -> each ready pulse appears 3 cycles after its req edge; the read returns rdata=0xDEADBEEF; err=0; busy high for 4 cycles per access.
- Misaligned: read addr=0x13 -> ready=1 and err=1 one cycle after req; rdata keeps its previous value; a following read of 0x10 still returns 0xDEADBEEF.
- Out of range, ADDR_W=8: write addr=0x400 with wdata=0x1 -> err=1; a subsequent read of addr=0x0 returns the unchanged prior value.
- Zero wait, WAIT_CYCLES=0: write 0x4 with 0x12345678, then read 0x4 -> each ready follows its req by 1 cycle; read returns 0x12345678.
- Request while busy: req pulses at N and again at N+1 and N+2 -> exactly one ready pulse; the later pulses are neither queued nor answered.
- Reset mid-write: write 0x8 with 0xCAFEF00D, assert rst during WAIT -> no ready; outputs are zero; a read of 0x8 after reset returns the old contents, not 0xCAFEF00D.
